// File: rtl/slot_pkg.sv
// Shared definitions for the slot machine money path: money width and
// ceiling, match codes, controller state encoding and saturation helpers.
package slot_pkg;

  localparam int MONEY_W   = 11;
  localparam int MONEY_MAX = 2047;
  localparam int CALC_W    = 16;

  localparam logic [1:0] MATCH_NONE    = 2'd0;
  localparam logic [1:0] MATCH_PAIR    = 2'd1;
  localparam logic [1:0] MATCH_TRIPLE  = 2'd2;
  localparam logic [1:0] MATCH_JACKPOT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPIN   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // Zero-extend a money value into the wide intermediate domain.
  function automatic logic [CALC_W-1:0] widen(input logic [MONEY_W-1:0] v);
    return CALC_W'(v);
  endfunction

  // Clamp a wide intermediate back into the money range.
  function automatic logic [MONEY_W-1:0] sat_money(input logic [CALC_W-1:0] v);
    if (v > CALC_W'(MONEY_MAX)) return MONEY_W'(MONEY_MAX);
    return v[MONEY_W-1:0];
  endfunction

endpackage

// File: rtl/payout_calc.sv
// Settlement arithmetic: match code -> multiplier -> payout, then the new
// balance (balance - invested + payout + bonus) saturated to the money range.
// Purely combinational so display/test logic can reuse it.
module payout_calc
  import slot_pkg::*;
#(
  parameter int MULT_PAIR    = 2,
  parameter int MULT_TRIPLE  = 5,
  parameter int MULT_JACKPOT = 20
) (
  input  logic [1:0]         match,
  input  logic [MONEY_W-1:0] balance,
  input  logic [MONEY_W-1:0] invested,
  input  logic [MONEY_W-1:0] bonus,
  output logic [MONEY_W-1:0] new_balance
);

  logic [CALC_W-1:0] mult;
  logic [CALC_W-1:0] payout;
  logic [CALC_W-1:0] total;

  // Multiplier lookup, payout and saturated settlement.
  always_comb begin
    mult = '0;
    case (match)
      MATCH_PAIR:    mult = CALC_W'(MULT_PAIR);
      MATCH_TRIPLE:  mult = CALC_W'(MULT_TRIPLE);
      MATCH_JACKPOT: mult = CALC_W'(MULT_JACKPOT);
      default:       mult = '0;
    endcase
    payout = widen(invested) * mult;
    // invested never exceeds balance, so the subtraction cannot wrap.
    total = widen(balance) - widen(invested) + payout + widen(bonus);
    new_balance = sat_money(total);
  end

endmodule

// File: rtl/spin_bet_controller.sv
// Money-path sequencer for the slot machine: coins, bets, spin launch,
// reel wait and payout settlement.
// Optional reel watchdog enabled by defining SPIN_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | accepting coins, bets and spin requests
// SPIN   | reels running; coins still accepted, waiting for reels_done
// SETTLE | one cycle: apply payout, clear invested
module spin_bet_controller
  import slot_pkg::*;
#(
  parameter int COIN_VALUE   = 10,
  parameter int BET_STEP     = 5,
  parameter int MAX_BET      = 50,
  parameter int MULT_PAIR    = 2,
  parameter int MULT_TRIPLE  = 5,
  parameter int MULT_JACKPOT = 20
`ifdef SPIN_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1023
`endif
) (
  input  logic               gameClk,
  input  logic               rst,
  input  logic               coin_btn,
  input  logic               bet_btn,
  input  logic               spin_btn,
  input  logic               reels_done,
  input  logic [1:0]         match_code,
  output logic               spin_start,
  output logic               busy,
  output logic [MONEY_W-1:0] current_balance,
  output logic [MONEY_W-1:0] current_money_invested,
  output logic               spin_fault
);

  localparam logic [CALC_W-1:0] COIN_W  = CALC_W'(COIN_VALUE);
  localparam logic [CALC_W-1:0] STEP_W  = CALC_W'(BET_STEP);
  localparam logic [CALC_W-1:0] MAXBET_W = CALC_W'(MAX_BET);

  state_t             state;
  logic [MONEY_W-1:0] balance;
  logic [MONEY_W-1:0] invested;
  logic [1:0]         match_q;
  logic [MONEY_W-1:0] coin_balance;
  logic [MONEY_W-1:0] settle_balance;
  logic [MONEY_W-1:0] bonus;
  logic [CALC_W-1:0]  bet_sum;
  logic               bet_ok;

`ifdef SPIN_TIMEOUT_EN
  logic [9:0] timer;
  logic       fault_q;
  logic       timer_tc;
  assign timer_tc = (timer == '0);
`endif

  // Coin is applied first; the bet check then sees the post-coin balance.
  always_comb begin
    coin_balance = balance;
    if (coin_btn) coin_balance = sat_money(widen(balance) + COIN_W);
    bet_sum = widen(invested) + STEP_W;
    bet_ok  = bet_btn && (bet_sum <= MAXBET_W) && (bet_sum <= widen(coin_balance));
    bonus   = coin_btn ? MONEY_W'(COIN_VALUE) : '0;
  end

  payout_calc #(
    .MULT_PAIR    (MULT_PAIR),
    .MULT_TRIPLE  (MULT_TRIPLE),
    .MULT_JACKPOT (MULT_JACKPOT)
  ) u_payout (
    .match       (match_q),
    .balance     (balance),
    .invested    (invested),
    .bonus       (bonus),
    .new_balance (settle_balance)
  );

  // Controller FSM with registered money registers and pulse outputs.
  always_ff @(posedge gameClk) begin
    if (rst) begin
      state      <= IDLE;
      balance    <= '0;
      invested   <= '0;
      match_q    <= MATCH_NONE;
      spin_start <= 1'b0;
`ifdef SPIN_TIMEOUT_EN
      timer      <= '0;
      fault_q    <= 1'b0;
`endif
    end else begin
      spin_start <= 1'b0;
`ifdef SPIN_TIMEOUT_EN
      fault_q    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          balance <= coin_balance;
          if (bet_ok) invested <= bet_sum[MONEY_W-1:0];
          // Spin qualifies on the pre-bet invested value.
          if (spin_btn && (invested != '0)) begin
            state      <= SPIN;
            spin_start <= 1'b1;
`ifdef SPIN_TIMEOUT_EN
            timer      <= 10'(TIMEOUT_CYCLES - 1);
`endif
          end
        end
        SPIN: begin
          balance <= coin_balance;
          if (reels_done) begin
            match_q <= match_code;
            state   <= SETTLE;
          end
`ifdef SPIN_TIMEOUT_EN
          else if (timer_tc) begin
            // Watchdog expiry refunds the bet by simply dropping it.
            invested <= '0;
            fault_q  <= 1'b1;
            state    <= IDLE;
          end else begin
            timer <= timer - 10'd1;
          end
`endif
        end
        SETTLE: begin
          balance  <= settle_balance;
          invested <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy                   = (state == SPIN) || (state == SETTLE);
  assign current_balance        = balance;
  assign current_money_invested = invested;

`ifdef SPIN_TIMEOUT_EN
  assign spin_fault = fault_q;
`else
  assign spin_fault = 1'b0;
`endif

endmodule

// File: doc/spin_bet_controller.md
Name: spin_bet_controller

Overview:
- Sequences the money datapath of the slot machine: accepts coins, commits bets, launches a spin, waits for the reels, then settles the payout.
- Owns the `current_balance` and `current_money_invested` registers that drive the display selector.
- Sits between the debounced button pulses and the reel/display logic, in the `gameClk` domain.

Parameters:
- COIN_VALUE, 10, amount added to balance per coin pulse
- BET_STEP, 5, amount moved into the invested total per bet pulse
- MAX_BET, 50, ceiling on `current_money_invested`
- MULT_PAIR, 2, payout multiplier for a pair
- MULT_TRIPLE, 5, payout multiplier for a triple
- MULT_JACKPOT, 20, payout multiplier for a jackpot
- TIMEOUT_CYCLES, 1023, reel watchdog limit (used only with the optional feature)

Ports:
- gameClk  in  1  game clock; all logic is on its rising edge
- rst  in  1  synchronous, active-high reset
- coin_btn  in  1  one-cycle pulse: coin inserted
- bet_btn  in  1  one-cycle pulse: raise bet
- spin_btn  in  1  one-cycle pulse: request spin
- reels_done  in  1  one-cycle pulse: reels stopped; `match_code` valid in the same cycle
- match_code  in  2  0 none, 1 pair, 2 triple, 3 jackpot
- spin_start  out  1  one-cycle pulse to the reel block
- busy  out  1  high in SPIN and SETTLE
- current_balance  out  11  total credits; includes the invested amount
- current_money_invested  out  11  credits committed to the next spin
- spin_fault  out  1  one-cycle pulse on reel timeout (optional feature only)

Behaviour:
- Reset: both money outputs are 0; `spin_start`, `busy` and `spin_fault` are 0; state is IDLE. Reset aborts any state, including mid-spin.
- State IDLE:
  - `coin_btn`: balance <= min(balance + COIN_VALUE, 2047).
  - `bet_btn`: invested += BET_STEP only if invested + BET_STEP <= MAX_BET and <= balance. Otherwise ignored, with no partial step.
  - `spin_btn` with invested > 0: next state is SPIN and `spin_start` pulses in the following cycle (one cycle of latency). With invested == 0 the request is ignored.
  - Same-cycle priority: coin is applied first, then bet is evaluated against the updated balance, then spin. Spin uses the pre-bet invested value; a bet in the same cycle still lands, and that spin settles on the new invested value.
- State SPIN:
  - `bet_btn` and `spin_btn` are ignored.
  - `coin_btn` is still accepted, with saturation.
  - On `reels_done`: latch `match_code`, go to SETTLE.
- State SETTLE (exactly 1 cycle):
  - payout = invested × multiplier(match_code), with multiplier 0 for none.
  - balance <= saturate11(balance − invested + payout), plus COIN_VALUE if `coin_btn` arrives in this same cycle.
  - invested <= 0; next state IDLE.
- Arithmetic:
  - Intermediates are 16 bits wide; the final value is saturated to 2047.
  - balance − invested never underflows, because invested <= balance is invariant.
- `busy` is combinationally decoded from state.

Optional Feature:
- Macro `SPIN_TIMEOUT_EN`.
- Defined:
  - A 10-bit counter runs in SPIN.
  - If `reels_done` has not arrived after TIMEOUT_CYCLES cycles: return to IDLE, leave balance unchanged, clear invested (the bet is refunded), and pulse `spin_fault` for one cycle.
  - A `reels_done` arriving in the same cycle as the timeout takes priority over the timeout.
- Undefined: no counter; SPIN waits indefinitely; `spin_fault` is tied to 0.

Decomposition:
- Shared package `slot_pkg` contains:
  - MONEY_W = 11 and MONEY_MAX = 2047
  - match_code constants MATCH_NONE / PAIR / TRIPLE / JACKPOT
  - state encoding IDLE / SPIN / SETTLE
- One sub-module, `payout_calc`: combinational match_code → multiplier → saturated new balance. It is reusable by the display and test logic.

Test Plan:
- Reset, 3 coins, 2 bets → balance 30, invested 10.
- 11 bets with balance 60 → invested stops at 50 (MAX_BET); with balance 12 → invested stops at 10.
- Spin with invested 10, balance 30, `reels_done` with match 2 → `spin_start` pulses 1 cycle after `spin_btn`; after SETTLE balance 70, invested 0.
- Balance 2040, invested 50, jackpot → balance saturates at 2047; a coin during SETTLE stays at 2047.
- `bet_btn` and `spin_btn` during SPIN are ignored; a coin during SPIN adds 10; `rst` asserted mid-SPIN → everything 0, state IDLE.
- With `SPIN_TIMEOUT_EN` defined and no `reels_done` → `spin_fault` pulses after 1023 cycles, balance unchanged, invested 0.
